// File: rtl/ycbcr_block_buffer_if.sv
// rtl/ycbcr_block_buffer_if.sv - pixel-in / planar-sample-out bundle for ycbcr_block_buffer
//
// Purpose
//   Groups the write-side pixel signals and the read-side sample handshake of
//   the YCbCr block buffer into one bundle.
//
// Signals
//   enable      source -> buffer   input pixel valid (no back-pressure exists)
//   data_in     source -> buffer   {Cr, Cb, Y}, block raster order
//   out_ready   sink   -> buffer   sink accepts the presented sample
//   data_out    buffer -> sink     sample (raw or level-shifted)
//   valid_out   buffer -> sink     data_out/comp_id/sample_idx/block_last valid
//   comp_id     buffer -> sink     0=Y 1=Cb 2=Cr
//   sample_idx  buffer -> sink     index within the current component
//   block_last  buffer -> sink     high with the final Cr sample of a block
//   overflow    buffer -> sink     sticky dropped-pixel flag
//
// Modports
//   master  the surroundings (converter + DCT stage)
//   slave   the buffer itself
interface ycbcr_block_buffer_if #(
    parameter int PIX_W   = 8,
    parameter int BLK_PIX = 64
);
    localparam int AW = $clog2(BLK_PIX);

    logic               enable;
    logic [3*PIX_W-1:0] data_in;
    logic               out_ready;
    logic [PIX_W-1:0]   data_out;
    logic               valid_out;
    logic [1:0]         comp_id;
    logic [AW-1:0]      sample_idx;
    logic               block_last;
    logic               overflow;

    modport master (
        output enable,
        output data_in,
        output out_ready,
        input  data_out,
        input  valid_out,
        input  comp_id,
        input  sample_idx,
        input  block_last,
        input  overflow
    );

    modport slave (
        input  enable,
        input  data_in,
        input  out_ready,
        output data_out,
        output valid_out,
        output comp_id,
        output sample_idx,
        output block_last,
        output overflow
    );
endinterface

// File: rtl/ycbcr_block_buffer.sv
// rtl/ycbcr_block_buffer.sv - ping-pong 8x8 block store, packed YCbCr in, planar Y/Cb/Cr out
//
// Purpose
//   Collects BLK_PIX packed {Cr,Cb,Y} pixels of one block into one of two banks
//   and replays a full bank as three planar streams (all Y, then all Cb, then
//   all Cr) over a valid/ready handshake. The write side cannot be stalled;
//   a pixel arriving while the target bank is still full is dropped and the
//   sticky overflow flag is raised.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   ycbcr_block_buffer_if.slave (pixel input, sample output, overflow)
//
// Configuration
//   YCBCR_LEVEL_SHIFT_EN  when defined, data_out = sample - 2^(PIX_W-1) in two's
//                         complement (MSB inverted); otherwise raw unsigned.
//
// Read-side structure
//   The FSM state plus rd_cnt form a fetch pointer: the next sample that will
//   be loaded into the output register. The register loads whenever it is
//   empty or its current sample is being transferred, so a sample is fetched
//   one cycle ahead of its transfer. After the last Cr sample has been fetched
//   the FSM parks in LAST_WAIT until that sample is actually transferred; only
//   then is the bank released, and the first Y of the other bank is fetched in
//   that same cycle when it is already full, giving back-to-back blocks.
module ycbcr_block_buffer #(
    parameter int PIX_W   = 8,
    parameter int BLK_PIX = 64
) (
    input  logic                clk,
    input  logic                rst,
    ycbcr_block_buffer_if.slave bus
);
    localparam int            AW       = $clog2(BLK_PIX);
    localparam logic [AW-1:0] LAST_IDX = AW'(BLK_PIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        OUT_Y,
        OUT_CB,
        OUT_CR,
        LAST_WAIT
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage: bank select is the MSB of the address
    // ------------------------------------------------------------------
    logic [3*PIX_W-1:0] mem [2*BLK_PIX];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic [1:0]    full;
    logic          overflow_r;

    logic          wr_accept;
    logic          wr_drop;
    logic          wr_done;
    logic [1:0]    set_full;
    logic [1:0]    clr_vec;

    assign wr_accept = bus.enable & ~full[wr_bank];
    assign wr_drop   = bus.enable &  full[wr_bank];
    assign wr_done   = wr_accept & (wr_cnt == LAST_IDX);
    assign set_full  = {wr_done & wr_bank, wr_done & ~wr_bank};

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank, wr_cnt}] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (wr_drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // A bank is only cleared while full and only written while empty, so the
    // set and clear masks never hit the same bank in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~clr_vec) | set_full;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t     state;
    rd_state_t     state_n;
    logic          rd_bank;
    logic          rd_bank_n;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_cnt_n;

    logic [PIX_W-1:0] data_r;
    logic             valid_r;
    logic             valid_n;
    logic [1:0]       comp_r;
    logic [AW-1:0]    idx_r;
    logic             last_r;

    logic             load_en;
    logic             transfer;
    logic             do_load;
    logic             clr_full;
    logic             fetch_bank;
    logic [1:0]       fetch_comp;
    logic [AW-1:0]    fetch_idx;
    logic             fetch_last;

    logic [3*PIX_W-1:0] fetch_word;
    logic [PIX_W-1:0]   sample;
    logic [PIX_W-1:0]   sample_out;

    assign load_en  = ~valid_r | bus.out_ready;
    assign transfer =  valid_r & bus.out_ready;
    assign clr_vec  = {clr_full & rd_bank, clr_full & ~rd_bank};

    always_comb begin
        state_n    = state;
        rd_cnt_n   = rd_cnt;
        rd_bank_n  = rd_bank;
        do_load    = 1'b0;
        clr_full   = 1'b0;
        fetch_bank = rd_bank;
        fetch_idx  = rd_cnt;
        fetch_comp = 2'd0;
        // An empty or just-transferred output register drops valid unless refilled.
        valid_n    = load_en ? 1'b0 : valid_r;

        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_n  = OUT_Y;
                    rd_cnt_n = '0;
                end
            end

            OUT_Y, OUT_CB, OUT_CR: begin
                if (state == OUT_CB) begin
                    fetch_comp = 2'd1;
                end else if (state == OUT_CR) begin
                    fetch_comp = 2'd2;
                end
                if (load_en) begin
                    do_load  = 1'b1;
                    rd_cnt_n = rd_cnt + 1'b1;
                    if (rd_cnt == LAST_IDX) begin
                        if (state == OUT_Y) begin
                            state_n = OUT_CB;
                        end else if (state == OUT_CB) begin
                            state_n = OUT_CR;
                        end else begin
                            state_n = LAST_WAIT;
                        end
                    end
                end
            end

            LAST_WAIT: begin
                // The register holds the final Cr sample; release the bank on its transfer.
                if (transfer) begin
                    clr_full  = 1'b1;
                    rd_bank_n = ~rd_bank;
                    if (full[~rd_bank]) begin
                        do_load    = 1'b1;
                        fetch_bank = ~rd_bank;
                        fetch_idx  = '0;
                        fetch_comp = 2'd0;
                        rd_cnt_n   = AW'(1);
                        state_n    = OUT_Y;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_load) begin
            valid_n = 1'b1;
        end
    end

    assign fetch_word = mem[{fetch_bank, fetch_idx}];
    assign fetch_last = (fetch_comp == 2'd2) && (fetch_idx == LAST_IDX);

    always_comb begin
        case (fetch_comp)
            2'd1:    sample = fetch_word[2*PIX_W-1:PIX_W];
            2'd2:    sample = fetch_word[3*PIX_W-1:2*PIX_W];
            default: sample = fetch_word[PIX_W-1:0];
        endcase
    end

`ifdef YCBCR_LEVEL_SHIFT_EN
    // Subtracting 2^(PIX_W-1) from an unsigned sample is an MSB inversion.
    assign sample_out = {~sample[PIX_W-1], sample[PIX_W-2:0]};
`else
    assign sample_out = sample;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            comp_r  <= 2'd0;
            idx_r   <= '0;
            last_r  <= 1'b0;
        end else begin
            state   <= state_n;
            rd_bank <= rd_bank_n;
            rd_cnt  <= rd_cnt_n;
            valid_r <= valid_n;
            if (do_load) begin
                data_r <= sample_out;
                comp_r <= fetch_comp;
                idx_r  <= fetch_idx;
                last_r <= fetch_last;
            end else if (load_en) begin
                last_r <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_r;
    assign bus.valid_out  = valid_r;
    assign bus.comp_id    = comp_r;
    assign bus.sample_idx = idx_r;
    assign bus.block_last = last_r;
    assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// tb/tb_ycbcr_block_buffer.sv - directed self-checking bench for ycbcr_block_buffer
module tb_ycbcr_block_buffer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ycbcr_block_buffer_if #(.PIX_W(8), .BLK_PIX(64)) bus ();

    ycbcr_block_buffer #(.PIX_W(8), .BLK_PIX(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // {data, comp, idx, last}
    logic [16:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] shf(input logic [7:0] x);
`ifdef YCBCR_LEVEL_SHIFT_EN
        return x ^ 8'h80;
`else
        return x;
`endif
    endfunction

    function automatic logic [23:0] pix_of(input int mode, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        case (mode)
            0:       return {kk + 8'd2, kk + 8'd1, kk};
            1:       return {8'hC0 ^ kk, 8'd255 - kk, kk * 8'd3 + 8'd9};
            2:       return {8'h11, 8'h22, kk + 8'd7};
            default: return {kk * 8'd5, kk + 8'd200, kk + 8'd100};
        endcase
    endfunction

    task automatic expect_block(input int mode, input int base);
        logic [23:0] p;
        logic [7:0]  s;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 64; i++) begin
                p = pix_of(mode, base + i);
                s = p[c*8 +: 8];
                exp_q.push_back({shf(s), 2'(c), 6'(i), 1'((c == 2) && (i == 63))});
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last pixel's rising edge.
    task automatic send(input int mode, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.enable  = 1'b1;
            bus.data_in = pix_of(mode, base + i);
            @(negedge clk);
        end
        bus.enable = 1'b0;
    endtask

    task automatic drain(input int n, input bit rnd, input string tag);
        int          got;
        int          cyc;
        int          limit;
        bit          started;
        bit          held;
        logic [17:0] prev;
        logic [17:0] cur;
        logic [16:0] e;
        got     = 0;
        cyc     = 0;
        limit   = n * 8 + 200;
        started = 1'b0;
        held    = 1'b0;
        prev    = '0;
        while (got < n && limit > 0) begin
            cur = {bus.valid_out, bus.data_out, bus.comp_id, bus.sample_idx, bus.block_last};
            if (held) chk({tag, "_hold"}, 32'(cur), 32'(prev));
            if (bus.valid_out) started = 1'b1;
            if (started) cyc++;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.valid_out && bus.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
                chk($sformatf("%s_xfer%0d", tag, got), 32'(cur[16:0]), 32'(e));
                got++;
            end
            held = bus.valid_out && !bus.out_ready;
            prev = cur;
            limit--;
            @(negedge clk);
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
        if (!rnd) chk({tag, "_nogap"}, 32'(cyc), 32'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] p;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("reset_outputs",
            32'({bus.valid_out, bus.data_out, bus.comp_id, bus.sample_idx, bus.block_last, bus.overflow}),
            32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic block, continuous ready, with latency check
        bus.out_ready = 1'b1;
        expect_block(0, 0);
        send(0, 0, 64);
        chk("lat_edge_n",   32'(bus.valid_out), 32'd0);
        @(negedge clk);
        chk("lat_edge_n1",  32'(bus.valid_out), 32'd0);
        @(negedge clk);
        chk("lat_edge_n2",  32'({bus.valid_out, bus.data_out, bus.comp_id, bus.sample_idx}),
            32'({1'b1, shf(8'h00), 2'd0, 6'd0}));
        drain(192, 1'b0, "t2");
        chk("t2_idle",      32'(bus.valid_out), 32'd0);
        chk("t2_no_ovf",    32'(bus.overflow),  32'd0);

        // Same block under random back-pressure
        expect_block(0, 0);
        send(0, 0, 64);
        drain(192, 1'b1, "t3");
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle",      32'(bus.valid_out), 32'd0);

        // Sink stalled: two blocks fill, the 129th pixel is dropped
        bus.out_ready = 1'b0;
        send(1, 0, 129);
        chk("t4_ovf",       32'(bus.overflow), 32'd1);
        p = pix_of(1, 0);
        chk("t4_stall_out", 32'({bus.valid_out, bus.data_out, bus.comp_id, bus.sample_idx}),
            32'({1'b1, shf(8'h09), 2'd0, 6'd0}));
        @(negedge clk);
        chk("t4_stall_hold", 32'({bus.valid_out, bus.data_out}), 32'({1'b1, shf(p[7:0])}));
        expect_block(1, 0);
        expect_block(1, 64);
        drain(384, 1'b0, "t4");
        chk("t4_empty",     32'(bus.valid_out), 32'd0);
        chk("t4_sticky",    32'(bus.overflow),  32'd1);

        // Asynchronous reset in the middle of a partial block
        bus.out_ready = 1'b0;
        send(2, 0, 64);
        send(2, 64, 20);
        chk("pre_rst",      32'({bus.valid_out, bus.overflow}), 32'b11);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid",   32'(bus.valid_out), 32'd0);
        chk("arst_ovf",     32'(bus.overflow),  32'd0);
        chk("arst_data",    32'(bus.data_out),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        expect_block(3, 0);
        send(3, 0, 64);
        drain(192, 1'b0, "t1");
        chk("t1_idle",      32'(bus.valid_out), 32'd0);
        chk("t1_no_ovf",    32'(bus.overflow),  32'd0);
        chk("queue_empty",  32'(exp_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
